// File: rtl/mealy_arb_pkg.sv
// Shared types and constants for the Mealy stream arbiter.
package mealy_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Index width for n requesters, never below one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mealy_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module mealy_rr_pick
  import mealy_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_req
);

  function automatic int wrap(input int a);
    return (a >= NUM_REQ) ? a - NUM_REQ : a;
  endfunction

  // Scan offsets from the pointer outward; the first hit wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any_req && req[j] && (j == wrap(int'(rr_ptr) + i))) begin
          gnt_oh[j] = 1'b1;
          gnt_idx   = ID_W'(j);
          any_req   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mealy_stream_arbiter.sv
// Round-robin arbiter sharing one serial Mealy detector between byte requesters.
// Optional build macro MEALY_ARB_CHAIN_EN: back-to-back jobs from the same
// requester skip the detector clear so patterns may span byte boundaries.
//
// state    | meaning
// ST_IDLE  | waiting for a request; grant and capture happen here
// ST_CLEAR | one-cycle detector clear, mask and bit counter reset
// ST_SHIFT | DATA_W cycles, one bit per cycle MSB-first, hit sampled per bit
// ST_DONE  | one-cycle response strobe
module mealy_stream_arbiter
  import mealy_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  localparam int ID_W   = id_w(NUM_REQ),
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      det_clr,
  output logic                      det_valid,
  output logic                      det_bit,
  input  logic                      det_hit,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_mask,
  output logic [CNT_W-1:0]          rsp_count
);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DATA_W-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               det_clr_q, det_clr_d;
  logic               det_valid_q, det_valid_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_mask_q, rsp_mask_d;
  logic [CNT_W-1:0]   rsp_count_c;
`ifdef MEALY_ARB_CHAIN_EN
  logic               last_id_valid_q, last_id_valid_d;
`endif

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  mealy_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any_req (pick_any)
  );

  // Next-state and datapath logic for the whole job sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    shift_d     = shift_q;
    id_d        = id_q;
    mask_d      = mask_q;
    bit_cnt_d   = bit_cnt_q;
    det_clr_d   = 1'b0;
    det_valid_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_mask_d  = rsp_mask_q;
`ifdef MEALY_ARB_CHAIN_EN
    last_id_valid_d = last_id_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) shift_d = req_data[i*DATA_W +: DATA_W];
          end
          id_d      = pick_idx;
          rr_ptr_d  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          mask_d    = '0;
          bit_cnt_d = CNT_W'(DATA_W - 1);
`ifdef MEALY_ARB_CHAIN_EN
          // id_q still names the previous job's requester until this edge.
          if (last_id_valid_q && (pick_idx == id_q)) begin
            state_d     = ST_SHIFT;
            det_valid_d = 1'b1;
          end else begin
            state_d   = ST_CLEAR;
            det_clr_d = 1'b1;
          end
          last_id_valid_d = 1'b1;
`else
          state_d   = ST_CLEAR;
          det_clr_d = 1'b1;
`endif
        end
      end
      ST_CLEAR: begin
        state_d     = ST_SHIFT;
        det_valid_d = 1'b1;
        mask_d      = '0;
        bit_cnt_d   = CNT_W'(DATA_W - 1);
      end
      ST_SHIFT: begin
        // Down-counter value equals the mask bit position of the bit on the wire.
        for (int i = 0; i < DATA_W; i++) begin
          if (bit_cnt_q == CNT_W'(i)) mask_d[i] = det_hit;
        end
        shift_d = shift_q << 1;
        if (bit_cnt_q == '0) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_mask_d  = mask_d;
          rsp_id_d    = id_q;
        end else begin
          bit_cnt_d   = bit_cnt_q - CNT_W'(1);
          det_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      shift_q     <= '0;
      id_q        <= '0;
      mask_q      <= '0;
      bit_cnt_q   <= '0;
      det_clr_q   <= 1'b0;
      det_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_mask_q  <= '0;
`ifdef MEALY_ARB_CHAIN_EN
      last_id_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      shift_q     <= shift_d;
      id_q        <= id_d;
      mask_q      <= mask_d;
      bit_cnt_q   <= bit_cnt_d;
      det_clr_q   <= det_clr_d;
      det_valid_q <= det_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_mask_q  <= rsp_mask_d;
`ifdef MEALY_ARB_CHAIN_EN
      last_id_valid_q <= last_id_valid_d;
`endif
    end
  end

  // Popcount of the held response mask.
  always_comb begin
    rsp_count_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rsp_count_c = rsp_count_c + CNT_W'(rsp_mask_q[i]);
    end
  end

  // Grant is the only same-cycle output; it is masked while reset is held.
  assign gnt       = ((state_q == ST_IDLE) && !rst) ? pick_oh : '0;
  assign busy      = (state_q != ST_IDLE);
  assign det_clr   = det_clr_q;
  assign det_valid = det_valid_q;
  assign det_bit   = det_valid_q & shift_q[DATA_W-1];
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_mask  = rsp_mask_q;
  assign rsp_count = rsp_count_c;

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// Self-checking bench for mealy_stream_arbiter with an overlapping "101" detector model.
module tb_mealy_stream_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [DW-1:0]  data [NR];
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  gnt;
  logic           busy, det_clr, det_valid, det_bit, det_hit, rsp_valid;
  logic [1:0]     rsp_id;
  logic [DW-1:0]  rsp_mask;
  logic [3:0]     rsp_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference-model state
  int  ptr        = 0;
  int  last_id    = 0;
  bit  last_valid = 1'b0;
  bit  seen[$];

  // Detector model: remembers the last two bits since its last clear.
  logic [1:0] hist = 2'b00;
  int         hcnt = 0;

  assign req_data = {data[3], data[2], data[1], data[0]};
  assign det_hit  = det_valid && det_bit && (hcnt >= 2) && (hist == 2'b10);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (det_clr) hcnt <= 0;
    else if (det_valid) begin
      hist <= {hist[0], det_bit};
      hcnt <= (hcnt < 2) ? hcnt + 1 : 2;
    end
  end

  mealy_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .busy      (busy),
    .det_clr   (det_clr),
    .det_valid (det_valid),
    .det_bit   (det_bit),
    .det_hit   (det_hit),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_mask  (rsp_mask),
    .rsp_count (rsp_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int ref_pick(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      if (r[(ptr + i) % NR]) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_det_clr"}, det_clr, 0);
    chk({tag, "_det_valid"}, det_valid, 0);
    chk({tag, "_det_bit"}, det_bit, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_mask"}, rsp_mask, 0);
    chk({tag, "_rsp_count"}, rsp_count, 0);
  endtask

  // One complete job, entered and left just after a rising edge with the DUT in IDLE.
  task automatic do_job(input logic [NR-1:0] r, input bit hold, input bit noise);
    int w;
    bit ch;
    int hits;
    logic [DW-1:0] d;
    logic [DW-1:0] m;
    logic [NR-1:0] oh;
    w  = ref_pick(r);
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    req = r;
    @(negedge clk);
    chk("gnt", gnt, oh);
    chk("busy_idle", busy, 0);
    if (w < 0) begin
      @(posedge clk); #1;
      return;
    end
    ch = 1'b0;
`ifdef MEALY_ARB_CHAIN_EN
    ch = last_valid && (last_id == w);
`endif
    if (!ch) seen.delete();
    d = data[w];
    m = '0;
    hits = 0;
    for (int k = 0; k < DW; k++) begin
      seen.push_back(d[DW-1-k]);
      if (seen.size() >= 3 && seen[$-2] && !seen[$-1] && seen[$]) begin
        m[DW-1-k] = 1'b1;
        hits++;
      end
    end
    ptr        = (w + 1) % NR;
    last_id    = w;
    last_valid = 1'b1;
    @(posedge clk); #1;
    req = hold ? r : (r & ~oh);
    if (!ch) begin
      @(negedge clk);
      chk("clr_det_clr", det_clr, 1);
      chk("clr_det_valid", det_valid, 0);
      chk("clr_busy", busy, 1);
      @(posedge clk); #1;
    end
    for (int k = 0; k < DW; k++) begin
      if (noise) req = 4'($urandom);
      @(negedge clk);
      chk("sh_det_valid", det_valid, 1);
      chk("sh_det_bit", det_bit, d[DW-1-k]);
      chk("sh_det_clr", det_clr, 0);
      chk("sh_gnt", gnt, 0);
      chk("sh_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_rsp_id", rsp_id, w);
    chk("done_rsp_mask", rsp_mask, m);
    chk("done_rsp_count", rsp_count, hits);
    chk("done_det_valid", det_valid, 0);
    if (!hold) req = '0;
    @(posedge clk); #1;
    if (noise && !hold) begin
      @(negedge clk);
      chk("quiet_gnt", gnt, 0);
      chk("quiet_busy", busy, 0);
      chk("hold_rsp_mask", rsp_mask, m);
      chk("quiet_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit ch;
    for (int i = 0; i < NR; i++) data[i] = '0;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single job and simple patterns on requester 0
    data[0] = 8'hAA; do_job(4'b0001, 1'b0, 1'b0);
    data[0] = 8'h00; do_job(4'b0001, 1'b0, 1'b0);
    data[0] = 8'h05; do_job(4'b0001, 1'b0, 1'b0);

    // Bring pointer back to 0, then fairness with all requests held high
    data[3] = 8'h3C; do_job(4'b1000, 1'b0, 1'b0);
    data[0] = 8'h15; data[1] = 8'hA5; data[2] = 8'h52; data[3] = 8'hFD;
    for (int i = 0; i < NR; i++) do_job(4'b1111, 1'b1, 1'b0);
    do_job(4'b1001, 1'b0, 1'b0);
    do_job(4'b1001, 1'b0, 1'b0);

    // Requests toggling while busy must not disturb the job
    data[0] = 8'hB5; do_job(4'b0001, 1'b0, 1'b1);

    // Back-to-back jobs from requester 1 across a byte boundary
    data[1] = 8'h01; do_job(4'b0010, 1'b0, 1'b0);
    data[1] = 8'h40; do_job(4'b0010, 1'b0, 1'b0);

    // Reset in the middle of SHIFT
    data[1] = 8'hFF;
    req = 4'b0010;
    @(negedge clk);
    chk("rst_pre_gnt", gnt, 4'b0010);
    ch = 1'b0;
`ifdef MEALY_ARB_CHAIN_EN
    ch = last_valid && (last_id == 1);
`endif
    @(posedge clk); #1;
    req = '0;
    if (!ch) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    ptr = 0;
    last_valid = 1'b0;
    seen.delete();
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DW + 3; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
      @(posedge clk); #1;
    end
    data[0] = 8'h5A; data[2] = 8'h77;
    do_job(4'b0101, 1'b0, 1'b0);

    // Randomized jobs
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < NR; j++) data[j] = 8'($urandom);
      do_job(4'($urandom_range(1, 15)), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
